cache_mem_backend: RTL
======================

Name: cache_mem_backend

Overview:
- Line-granular main-memory model sitting directly downstream of the data cache in the MW stage; the cache refills lines from it and writes dirty lines back to it.
- Single-outstanding request/grant handshake with a fixed, parameterised access latency, so the cache miss/stall path is exercised with realistic timing.
- Keeps completed-transaction counters beside the hit/miss counters for cache performance measurement.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (line = 2^LINE_ADDR_LEN 32-bit words, default 8 words = 256 bits).
- MEM_ADDR_LEN, 9, line-address width (TAG_ADDR_LEN + SET_ADDR_LEN of the cache, default 2^9 = 512 lines).
- LATENCY, 50, cycles from request sample to grant; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- mem_rd_req  in  1  line read request; held by the requester until mem_gnt.
- mem_wr_req  in  1  line write-back request; held by the requester until mem_gnt.
- mem_addr  in  MEM_ADDR_LEN  line address (word address bits above LINE_ADDR_LEN).
- mem_wr_line  in  32*2^LINE_ADDR_LEN  write-back data; word i occupies bits [32i+31:32i].
- mem_rd_line  out  32*2^LINE_ADDR_LEN  read data, valid while mem_gnt=1 for a read.
- mem_gnt  out  1  one-cycle completion pulse.
- mem_busy  out  1  high in the BUSY and DONE states.
- rd_cnt  out  32  count of completed reads.
- wr_cnt  out  32  count of completed writes.

Behaviour:
- Storage:
  - Word array of 2^(MEM_ADDR_LEN+LINE_ADDR_LEN) x 32 bits, zero-initialised at time 0.
  - Reset does not clear the array.
- States: IDLE, BUSY, DONE. Reset value of every output is 0 and the state is IDLE; the latched op, address, data and the latency counter are cleared.
- IDLE:
  - At a posedge with mem_wr_req or mem_rd_req high, latch the op, mem_addr and mem_wr_line.
  - Then go to BUSY with cnt=0.
  - If both requests are high, the write wins and the read is not latched; the requester keeps mem_rd_req high and it is served next.
- BUSY:
  - cnt increments at each posedge.
  - At the posedge where cnt==LATENCY-1 (LATENCY=1: the first posedge in BUSY), go to DONE. On that same edge:
    - For a write, commit all 2^LINE_ADDR_LEN words of the latched line and increment wr_cnt.
    - For a read, load mem_rd_line from the array and increment rd_cnt.
  - Request inputs are ignored while BUSY; address and data changes have no effect.
- DONE:
  - mem_gnt=1 for exactly one cycle, then go to IDLE unconditionally.
  - Requests seen during DONE are ignored, because the requester is still holding the completed request.
  - A new request is sampled no earlier than the first posedge in IDLE.
- Latency: a request sampled at edge E0 gives mem_gnt high in the cycle after edge E0+LATENCY. That is LATENCY cycles of wait, and a back-to-back minimum of LATENCY+2 cycles per transaction.
- mem_rd_line holds its last value until the next read completes; it is not updated by writes.
- Read-after-write to the same line returns the newly written data.
- mem_gnt, mem_rd_line, mem_busy, rd_cnt and wr_cnt are all registered; there is no combinational input-to-output path.
- The counters wrap modulo 2^32.
- Reset mid-transaction: the machine returns to IDLE immediately and asynchronously, mem_gnt is forced to 0, and the pending operation is dropped. A write not yet committed does not reach the array.

Test Plan:
- Reset, then wait 5 cycles -> mem_gnt=0, mem_busy=0, rd_cnt=wr_cnt=0, mem_rd_line=0.
- LATENCY=4: write line 0x05 with word i = 0xA0000000+i, hold mem_wr_req -> mem_gnt high exactly 4 cycles after the sample edge, one cycle wide; wr_cnt=1.
- Read line 0x05 -> mem_gnt after 4 cycles; mem_rd_line word0=0xA0000000 and word7=0xA0000007; rd_cnt=1.
- Assert mem_rd_req and mem_wr_req together, line 0x10 -> write served first (wr_cnt=2, rd_cnt=1); the held read is then served and returns the just-written data (rd_cnt=2); the two grants are at least 6 cycles apart.
- Start a write to line 0x20, assert rst at cnt=2 -> mem_gnt never pulses, state IDLE, wr_cnt=0; a later read of 0x20 returns all zeros.
- LATENCY=1: a read request held continuously -> grants every 3 cycles, and rd_cnt increments once per grant.

Source files
------------

// File: rtl/cache_mem_backend_if.sv
// Request/grant bus between the data cache and its line-granular backing memory.
interface cache_mem_backend_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 9
);
  localparam int LINE_W = 32 * (2 ** LINE_ADDR_LEN);

  logic                    mem_rd_req;
  logic                    mem_wr_req;
  logic [MEM_ADDR_LEN-1:0] mem_addr;
  logic [LINE_W-1:0]       mem_wr_line;
  logic [LINE_W-1:0]       mem_rd_line;
  logic                    mem_gnt;
  logic                    mem_busy;
  logic [31:0]             rd_cnt;
  logic [31:0]             wr_cnt;

  // Cache side: raises requests and holds them until mem_gnt.
  modport master (
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
    input  mem_rd_line, mem_gnt, mem_busy, rd_cnt, wr_cnt
  );

  // Memory side: serves one request at a time with a fixed latency.
  modport slave (
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
    output mem_rd_line, mem_gnt, mem_busy, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/cache_mem_backend.sv
// Line-granular main-memory model behind the data cache. One request is
// accepted at a time; the grant arrives a fixed LATENCY (1..255) cycles after
// the request is sampled, followed by a single DONE cycle. Completed reads and
// writes are counted for cache performance measurement.
module cache_mem_backend #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 9,
  parameter int LATENCY       = 50
) (
  input logic                clk,
  input logic                rst,
  cache_mem_backend_if.slave bus
);
  localparam int         WORDS    = 2 ** LINE_ADDR_LEN;
  localparam int         LINE_W   = 32 * WORDS;
  localparam int         DEPTH    = 2 ** (MEM_ADDR_LEN + LINE_ADDR_LEN);
  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [7:0]              cnt;
  logic                    op_wr;
  logic [MEM_ADDR_LEN-1:0] addr_q;
  logic [LINE_W-1:0]       line_q;
  logic                    accept;
  logic                    finish;
  logic [LINE_W-1:0]       rd_data;

  // Backing store starts out all zeros and is deliberately left alone by reset.
  logic [31:0] mem [DEPTH] = '{default: '0};

  // State register; reset drops any in-flight transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the accept/finish strobes that steer the datapath.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_wr_req || bus.mem_rd_req) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST_CNT) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gather the addressed line from the word array for a completing read.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      rd_data[32*i +: 32] = mem[{addr_q, LINE_ADDR_LEN'(i)}];
    end
  end

  // Request latch, latency counter, registered outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt             <= '0;
      op_wr           <= 1'b0;
      addr_q          <= '0;
      line_q          <= '0;
      bus.mem_gnt     <= 1'b0;
      bus.mem_busy    <= 1'b0;
      bus.mem_rd_line <= '0;
      bus.rd_cnt      <= '0;
      bus.wr_cnt      <= '0;
    end else begin
      bus.mem_gnt  <= finish;
      bus.mem_busy <= (state_nxt != IDLE);
      if (accept) begin
        // A simultaneous read stays held by the requester and is served next.
        op_wr  <= bus.mem_wr_req;
        addr_q <= bus.mem_addr;
        line_q <= bus.mem_wr_line;
        cnt    <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end
      if (finish) begin
        if (op_wr) begin
          bus.wr_cnt <= bus.wr_cnt + 32'd1;
        end else begin
          bus.rd_cnt      <= bus.rd_cnt + 32'd1;
          bus.mem_rd_line <= rd_data;
        end
      end
    end
  end

  // Commit a write-back line on its completion edge.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; contents must survive reset, and a
    // resettable array this size would not map onto RAM. An aborted write never
    // reaches here because reset forces the state, and so finish, low.
    if (finish && op_wr) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[{addr_q, LINE_ADDR_LEN'(i)}] <= line_q[32*i +: 32];
      end
    end
  end
endmodule
